// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a double-buffered multi-digit BCD value onto one shared
// seven-segment decoder, with anti-ghosting gaps, leading-zero blanking and invalid-digit flagging.
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 50000,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    lzb_en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    bad_digit,
    output logic                    frame_start
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [IW-1:0]           r_idx;
    logic [IW-1:0]           w_idx_nxt;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_slot_start;

    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic                    r_pending;

    logic [3:0]              w_cur_digit;
    logic                    w_upper_zero;
    logic                    w_suppress;

    logic [3:0]              r_bcd;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic                    r_bad;
    logic                    r_fs;
    logic                    r_sup;

    // State register and slot/index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_slot_end  = 1'b0;
        case (r_state)
            ST_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                    w_slot_end  = 1'b1;
                    w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_frame_end  = w_slot_end && (r_idx == IDX_LAST);
    assign w_slot_start = (r_state == ST_GAP) && (r_cnt == '0);

    // A load on the boundary cycle itself beats the older shadow contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= digits_in;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_active <= digits_in;
                end else if (r_pending) begin
                    r_active <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_cur_digit = r_active[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(r_idx)) && (r_active[4*j +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
    end

    assign w_suppress = (lzb_en && (r_idx != '0) && w_upper_zero) || (w_cur_digit > 4'd9);

    // Outputs are decoded from the counter state one cycle earlier, so every
    // output is a plain register and the whole slot pattern is shifted by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd  <= '0;
            r_bad  <= 1'b0;
            r_sup  <= 1'b0;
            r_fs   <= 1'b0;
            r_an_n <= '1;
        end else begin
            if (w_slot_start) begin
                r_bcd <= w_cur_digit;
                r_bad <= (w_cur_digit > 4'd9);
                r_sup <= w_suppress;
            end
            r_fs   <= w_slot_start && (r_idx == '0);
            r_an_n <= ((r_state == ST_ON) && !r_sup) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
        end
    end

    assign bcd_out     = r_bcd;
    assign an_n        = r_an_n;
    assign bad_digit   = r_bad;
    assign frame_start = r_fs;

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Upstream stage of the BCD-to-seven-segment decoder: holds a multi-digit BCD value and time-multiplexes it onto one shared decoder.
- Each scan slot presents one digit nibble to the decoder inputs and asserts that digit's active-low anode enable.
- New values are double-buffered and take effect only at a frame boundary, so a display update never tears mid-frame.
- Also provides leading-zero blanking, anti-ghosting blank gaps and invalid-digit flagging.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, ≥2; digit NUM_DIGITS-1 is the most significant.
- SLOT_CYCLES, 50000: clock cycles per digit slot; must exceed GAP_CYCLES.
- GAP_CYCLES, 2: cycles at the start of each slot with all anodes off; must be ≥1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  capture digits_in into the shadow register this cycle
- digits_in  input  4*NUM_DIGITS  packed BCD; digit i is at [4i+3:4i]
- lzb_en  input  1  leading-zero blanking enable
- bcd_out  output  4  current digit nibble to the decoder; bit3 maps to decoder input A, bit0 to D
- an_n  output  NUM_DIGITS  active-low anode enables, at most one low at a time
- bad_digit  output  1  high for the whole current slot if the digit is >9
- frame_start  output  1  one-cycle pulse at the first cycle of the slot for digit 0

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - bcd_out=0, an_n=all 1, bad_digit=0, frame_start=0.
  - Slot counter=0, digit index=0, state=GAP.
  - Shadow and active digit registers=0, pending=0.
- Slot timing: each slot is exactly SLOT_CYCLES cycles.
  - GAP phase: the first GAP_CYCLES cycles, an_n all 1.
  - ON phase: the remaining SLOT_CYCLES-GAP_CYCLES cycles, an_n[idx]=0 unless the digit is suppressed.
  - A frame is NUM_DIGITS*SLOT_CYCLES cycles. Index order is 0,1,…,NUM_DIGITS-1, then wraps to 0.
- State machine:
  - GAP → ON when the slot counter reaches GAP_CYCLES-1.
  - ON → GAP when the slot counter reaches SLOT_CYCLES-1. At that point the slot counter clears and the index advances, wrapping to 0 after NUM_DIGITS-1.
- All outputs are registered and change only at slot-counter edges.
- At the first GAP cycle of every slot:
  - bcd_out and bad_digit update from the active register for the new index.
  - They hold for the entire slot.
- frame_start is high for exactly the first GAP cycle of slot 0. Its first assertion is the first cycle after reset release.
- Load handshake: no backpressure; load is accepted every cycle.
  - load=1 writes shadow<=digits_in and sets pending=1. The last write in a frame wins.
- Frame boundary is the cycle where ON→GAP occurs with index NUM_DIGITS-1.
  - If pending=1: active<=shadow, pending<=0.
  - If load=1 on the boundary cycle: active<=digits_in directly, pending<=0. The same-cycle load wins over the older shadow.
  - The new active value is therefore visible starting with the slot-0 of the next frame.
- Suppression: the digit still occupies its slot time, but an_n stays all 1 during its ON phase. A digit is suppressed when either of these holds:
  - Leading-zero blank: lzb_en=1, idx≠0, and active digits NUM_DIGITS-1 down to idx are all 0. Digit 0 is never blanked.
  - Invalid digit: value >9. bad_digit=1 for that slot and bcd_out still carries the raw nibble.
- lzb_en is sampled at each slot start, so changing it affects only the next slot.
- Reset mid-operation: all state returns immediately to reset values and any pending load is discarded.

Test Plan (NUM_DIGITS=4, SLOT_CYCLES=8, GAP_CYCLES=2):
- Reset release, load 0x1234 once, lzb_en=0 → from the second frame, the slot sequence shows:
  - bcd_out 4,3,2,1 for idx 0..3.
  - an_n 1110,1101,1011,0111 for 6 cycles each, preceded by 2 cycles of 1111.
  - frame_start pulses every 32 cycles.
- Load 0x0070, lzb_en=1 → slots 3 and 2 keep an_n=1111 throughout; slot 1 lights bcd_out=7; slot 0 lights bcd_out=0.
- Load 0x0000, lzb_en=1 → only slot 0 lit, showing 0.
- Load 0x12A4 → slot 1 has bad_digit=1, bcd_out=1010, an_n stays 1111; the other slots display normally.
- Load 0x1111 mid-frame, then 0x2222 two cycles later → the current frame still shows the old value; the next frame shows 2222.
- Load 0x3333 on the exact boundary cycle while 0x5555 is pending → the next frame shows 3333.
- Assert rst_n low mid-ON phase → an_n=1111 and bcd_out=0 immediately (asynchronous). After release, the display shows 0000 until a new load.
